// File: rtl/cla_seq_pkg.sv
// Shared types and constants for the multi-word CLA sequencer.
// State encoding, default geometry and the word-index width helper.
package cla_seq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam int N_DEF     = 16;
   localparam int WORDS_DEF = 4;

   function automatic int idx_w(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/cla_multiword_seq_if.sv
// Requester-side bus of the multi-word CLA sequencer (start/done handshake, operands, result).
// Optional macro CLA_SEQ_OVF_EN adds the signed-overflow flag ovf.
interface cla_multiword_seq_if
   import cla_seq_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int WORDS = WORDS_DEF
);
   localparam int W = N * WORDS;

   logic         start;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         cin;
   logic [W-1:0] sum;
   logic         cout;
   logic         busy;
   logic         done;
`ifdef CLA_SEQ_OVF_EN
   logic         ovf;

   modport master (output start, a_in, b_in, cin, input sum, cout, busy, done, ovf);
   modport slave  (input start, a_in, b_in, cin, output sum, cout, busy, done, ovf);
`else
   modport master (output start, a_in, b_in, cin, input sum, cout, busy, done);
   modport slave  (input start, a_in, b_in, cin, output sum, cout, busy, done);
`endif

endinterface

// File: rtl/cla_slice_cin.sv
// N-bit combinational carry-look-ahead adder with carry-in; every carry is a flat
// generate/propagate product term. CLA_SEQ_OVF_EN exposes the carry into the MSB.
module cla_slice_cin #(
   parameter int N = 16
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
`ifdef CLA_SEQ_OVF_EN
   output logic         c_msb,
`endif
   output logic         cout
);
   logic [N-1:0] g;
   logic [N-1:0] p;
   logic [N:0]   c;

   assign g = a & b;
   assign p = a ^ b;

   // c[i] = g[i-1] | p[i-1]g[i-2] | ... | p[i-1..0]cin, built without a ripple chain
   always_comb begin
      logic acc;
      logic pp;
      acc = 1'b0;
      pp  = 1'b1;
      c   = '0;
      c[0] = cin;
      for (int i = 1; i <= N; i++) begin
         acc = 1'b0;
         pp  = 1'b1;
         for (int j = i - 1; j >= 0; j--) begin
            acc = acc | (pp & g[j]);
            pp  = pp & p[j];
         end
         c[i] = acc | (pp & cin);
      end
   end

   assign sum  = p ^ c[N-1:0];
   assign cout = c[N];
`ifdef CLA_SEQ_OVF_EN
   assign c_msb = c[N-1];
`endif

endmodule

// File: rtl/cla_multiword_seq.sv
// Wide adder that time-multiplexes one N-bit CLA slice, one word per clock, LSW first.
// Optional macro CLA_SEQ_OVF_EN adds a registered two's-complement overflow flag.
module cla_multiword_seq
   import cla_seq_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int WORDS = WORDS_DEF
) (
   input logic                clk,
   input logic                rst,
   cla_multiword_seq_if.slave bus
);
   localparam int IDX_W = idx_w(WORDS);
   localparam int W     = N * WORDS;

   state_t             state;
   state_t             state_nxt;
   logic [IDX_W-1:0]   idx;
   logic               carry;
   logic [N-1:0]       a_words   [WORDS];
   logic [N-1:0]       b_words   [WORDS];
   logic [N-1:0]       sum_words [WORDS];
   logic [W-1:0]       sum_flat;
   logic               cout_r;
   logic               last_word;
   logic [N-1:0]       slice_sum;
   logic               slice_cout;
`ifdef CLA_SEQ_OVF_EN
   logic               slice_cmsb;
   logic               ovf_r;
`endif

   assign last_word = (idx == IDX_W'(WORDS - 1));

   cla_slice_cin #(.N(N)) u_slice (
      .a     (a_words[idx]),
      .b     (b_words[idx]),
      .cin   (carry),
      .sum   (slice_sum),
`ifdef CLA_SEQ_OVF_EN
      .c_msb (slice_cmsb),
`endif
      .cout  (slice_cout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = RUN;
         RUN:     if (last_word) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state != IDLE);
      bus.done = (state == DONE);
   end

   // Operand capture and word-serial accumulation; start outside IDLE never reaches here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx    <= '0;
         carry  <= 1'b0;
         cout_r <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
         ovf_r  <= 1'b0;
`endif
         for (int i = 0; i < WORDS; i++) begin
            a_words[i]   <= '0;
            b_words[i]   <= '0;
            sum_words[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  idx   <= '0;
                  carry <= bus.cin;
                  for (int i = 0; i < WORDS; i++) begin
                     a_words[i] <= bus.a_in[i*N +: N];
                     b_words[i] <= bus.b_in[i*N +: N];
                  end
               end
            end
            RUN: begin
               sum_words[idx] <= slice_sum;
               carry          <= slice_cout;
               if (last_word) begin
                  idx    <= '0;
                  cout_r <= slice_cout;
`ifdef CLA_SEQ_OVF_EN
                  ovf_r  <= slice_cmsb ^ slice_cout;
`endif
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      sum_flat = '0;
      for (int i = 0; i < WORDS; i++) sum_flat[i*N +: N] = sum_words[i];
   end

   assign bus.sum  = sum_flat;
   assign bus.cout = cout_r;
`ifdef CLA_SEQ_OVF_EN
   assign bus.ovf  = ovf_r;
`endif

endmodule
